// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: AX.25/HDLC transmit framer, one line bit per clk_1200 cycle.
//   Pulls bytes from the transmit buffer, wraps them in 0x7E flags, appends the
//   CRC-16/X.25 FCS, bit-stuffs the data/FCS field and NRZI-encodes the result.
//   Optional feature macro: HDLC_FCS_EN (defined = CRC/FCS state present;
//   undefined = no CRC logic, DATA goes straight to POSTAMBLE).
// Ports:
//   clk_1200  in   bit clock
//   reset     in   synchronous active-high reset
//   start     in   frame request, honoured only in IDLE
//   tx_byte   in   byte from the buffer, valid while dav_tx=1
//   dav_tx    in   buffer holds a byte
//   tx_empty  in   buffer has no more bytes for this frame
//   rfd_tx    out  holding register empty (PREAMBLE/DATA only)
//   ack_tx    out  1-cycle pulse: tx_byte captured
//   tx_bit    out  NRZI line bit
//   ptt       out  transmitter keyed
//   tx_done   out  1-cycle pulse after the last postamble bit
//   tx_abort  out  1-cycle pulse after the abort sequence
//
// state      | meaning
// S_IDLE     | line idle, waiting for start
// S_PREAMBLE | opening flags
// S_DATA     | buffer bytes, stuffed, CRC updated
// S_FCS      | two FCS bytes, stuffed
// S_POSTAMBLE| closing flags, then one tail cycle for tx_done
// S_ABORT    | eight unstuffed ones, then one tail cycle for tx_abort
module hdlc_tx_framer #(
    parameter int PREAMBLE_FLAGS  = 16,
    parameter int POSTAMBLE_FLAGS = 2
) (
    input  logic       clk_1200,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       dav_tx,
    input  logic       tx_empty,
    output logic       rfd_tx,
    output logic       ack_tx,
    output logic       tx_bit,
    output logic       ptt,
    output logic       tx_done,
    output logic       tx_abort
);
    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_DATA, S_FCS, S_POSTAMBLE, S_ABORT
    } state_t;

    localparam logic [7:0] FLAG = 8'h7E;
    localparam int CNT_MAX = (PREAMBLE_FLAGS > POSTAMBLE_FLAGS) ? PREAMBLE_FLAGS : POSTAMBLE_FLAGS;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_FLAGS - 1);
    localparam logic [CNT_W-1:0] POST_END = CNT_W'(POSTAMBLE_FLAGS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       ones_q, ones_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             tx_bit_q, tx_bit_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
`ifdef HDLC_FCS_EN
    logic [15:0]      crc_q, crc_d, crc_next;
`endif

    logic       capture, next_avail, stuff, cur_bit, last_bit, line_bit;
    logic [7:0] next_byte, shift_adv;
    logic [2:0] bit_cnt_adv, ones_next;

    assign rfd_tx     = ((state_q == S_PREAMBLE) || (state_q == S_DATA)) && !hold_full_q;
    assign capture    = rfd_tx && dav_tx;
    // A byte arriving on the very boundary edge goes straight to the shift register.
    assign next_avail = hold_full_q || capture;
    assign next_byte  = hold_full_q ? hold_q : tx_byte;
    // POSTAMBLE is included so that a field ending in five ones still gets its
    // stuffed zero before the closing flag.
    assign stuff      = ((state_q == S_DATA) || (state_q == S_FCS) || (state_q == S_POSTAMBLE))
                        && (ones_q == 3'd5);
    assign cur_bit    = stuff ? 1'b0 : shift_q[0];
    assign last_bit   = !stuff && (bit_cnt_q == 3'd7);
    assign line_bit   = cur_bit ? tx_bit_q : ~tx_bit_q;
    assign shift_adv  = stuff ? shift_q : {1'b0, shift_q[7:1]};
    assign bit_cnt_adv = stuff ? bit_cnt_q : bit_cnt_q + 3'd1;
    assign ones_next  = (stuff || !cur_bit) ? 3'd0 : ones_q + 3'd1;
`ifdef HDLC_FCS_EN
    assign crc_next   = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ cur_bit) ? 16'h8408 : 16'h0000);
`endif

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        cnt_d       = cnt_q;
        ones_d      = ones_q;
        hold_d      = capture ? tx_byte : hold_q;
        hold_full_d = hold_full_q || capture;
        tx_bit_d    = tx_bit_q;
        ack_d       = capture;
        done_d      = 1'b0;
        abort_d     = 1'b0;
`ifdef HDLC_FCS_EN
        crc_d       = crc_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Flag bit 0 (a zero) goes out on this edge.
                    state_d   = S_PREAMBLE;
                    tx_bit_d  = ~tx_bit_q;
                    shift_d   = {1'b0, FLAG[7:1]};
                    bit_cnt_d = 3'd1;
                    cnt_d     = '0;
                    ones_d    = '0;
`ifdef HDLC_FCS_EN
                    crc_d     = 16'hFFFF;
`endif
                end
            end
            S_PREAMBLE: begin
                tx_bit_d  = line_bit;
                shift_d   = shift_adv;
                bit_cnt_d = bit_cnt_adv;
                if (last_bit) begin
                    if (cnt_q != PRE_LAST) begin
                        shift_d = FLAG;
                        cnt_d   = cnt_q + CNT_ONE;
                    end else if (next_avail) begin
                        state_d     = S_DATA;
                        shift_d     = next_byte;
                        hold_full_d = 1'b0;
                    end else if (tx_empty) begin
                        state_d = S_POSTAMBLE;
                        shift_d = FLAG;
                        cnt_d   = '0;
                    end else begin
                        state_d     = S_ABORT;
                        shift_d     = 8'hFF;
                        cnt_d       = '0;
                        hold_full_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                tx_bit_d  = line_bit;
                shift_d   = shift_adv;
                bit_cnt_d = bit_cnt_adv;
                ones_d    = ones_next;
`ifdef HDLC_FCS_EN
                if (!stuff) crc_d = crc_next;
`endif
                if (last_bit) begin
                    if (next_avail) begin
                        shift_d     = next_byte;
                        hold_full_d = 1'b0;
                    end else if (tx_empty) begin
`ifdef HDLC_FCS_EN
                        state_d = S_FCS;
                        shift_d = ~crc_next[7:0];
                        cnt_d   = '0;
`else
                        state_d = S_POSTAMBLE;
                        shift_d = FLAG;
                        cnt_d   = '0;
                        if (ones_next != 3'd5) ones_d = '0;
`endif
                    end else begin
                        state_d     = S_ABORT;
                        shift_d     = 8'hFF;
                        cnt_d       = '0;
                        ones_d      = '0;
                        hold_full_d = 1'b0;
                    end
                end
            end
`ifdef HDLC_FCS_EN
            S_FCS: begin
                tx_bit_d  = line_bit;
                shift_d   = shift_adv;
                bit_cnt_d = bit_cnt_adv;
                ones_d    = ones_next;
                if (last_bit) begin
                    if (cnt_q == '0) begin
                        shift_d = ~crc_q[15:8];
                        cnt_d   = CNT_ONE;
                    end else begin
                        state_d = S_POSTAMBLE;
                        shift_d = FLAG;
                        cnt_d   = '0;
                        if (ones_next != 3'd5) ones_d = '0;
                    end
                end
            end
`endif
            S_POSTAMBLE: begin
                if (cnt_q == POST_END) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    tx_bit_d  = line_bit;
                    shift_d   = shift_adv;
                    bit_cnt_d = bit_cnt_adv;
                    if (stuff) ones_d = '0;
                    if (last_bit) begin
                        shift_d = FLAG;
                        cnt_d   = cnt_q + CNT_ONE;
                    end
                end
            end
            S_ABORT: begin
                if (cnt_q == CNT_ONE) begin
                    state_d     = S_IDLE;
                    abort_d     = 1'b1;
                    hold_full_d = 1'b0;
                end else begin
                    tx_bit_d  = line_bit;
                    shift_d   = shift_adv;
                    bit_cnt_d = bit_cnt_adv;
                    if (last_bit) cnt_d = CNT_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_1200) begin
        if (reset) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            cnt_q       <= '0;
            ones_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_bit_q    <= 1'b0;
            ack_q       <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
`ifdef HDLC_FCS_EN
            crc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            cnt_q       <= cnt_d;
            ones_q      <= ones_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_bit_q    <= tx_bit_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
`ifdef HDLC_FCS_EN
            crc_q       <= crc_d;
`endif
        end
    end

    assign ack_tx   = ack_q;
    assign tx_bit   = tx_bit_q;
    assign ptt      = (state_q != S_IDLE);
    assign tx_done  = done_q;
    assign tx_abort = abort_q;
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Testbench for hdlc_tx_framer: table of directed frames plus random frames,
// line output NRZI-decoded and compared against a bit-stream reference model.
module tb_hdlc_tx_framer;
    localparam int PRE  = 2;
    localparam int POST = 1;
`ifdef HDLC_FCS_EN
    localparam int NB3 = 11;
`else
    localparam int NB3 = 10;
`endif

    logic       clk_1200 = 1'b0;
    logic       reset, start, dav_tx, tx_empty;
    logic [7:0] tx_byte;
    logic       rfd_tx, ack_tx, tx_bit, ptt, tx_done, tx_abort;

    always #5 clk_1200 = ~clk_1200;

    hdlc_tx_framer #(.PREAMBLE_FLAGS(PRE), .POSTAMBLE_FLAGS(POST)) dut (
        .clk_1200(clk_1200), .reset(reset), .start(start), .tx_byte(tx_byte),
        .dav_tx(dav_tx), .tx_empty(tx_empty), .rfd_tx(rfd_tx), .ack_tx(ack_tx),
        .tx_bit(tx_bit), .ptt(ptt), .tx_done(tx_done), .tx_abort(tx_abort)
    );

    typedef struct {
        logic [71:0] data;
        int          n;
        bit          ab;
        int          exp_acks;
        bit          exp_done;
        bit          exp_abort;
        int          exp_len;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fb [16];
    int         fn;
    bit         fab;
    bit         exp_q [$];
    bit         rec_q [$];
    logic [7:0] ref3 [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_1200);
        @(negedge clk_1200);
    endtask

`ifdef HDLC_FCS_EN
    function automatic logic [15:0] crc_x25();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < fn; i++)
            for (int j = 0; j < 8; j++)
                c = (c[0] ^ fb[i][j]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction
`endif

    // Expected line bit stream (before NRZI) from the framing rules.
    task automatic build_exp();
        bit         d [$];
        int         ones;
        logic [7:0] fl;
        logic [15:0] f;
        fl = 8'h7E;
        f  = '0;
        exp_q.delete();
        for (int k = 0; k < PRE; k++)
            for (int j = 0; j < 8; j++) exp_q.push_back(fl[j]);
        for (int i = 0; i < fn; i++)
            for (int j = 0; j < 8; j++) d.push_back(fb[i][j]);
`ifdef HDLC_FCS_EN
        if (!fab) begin
            f = ~crc_x25();
            for (int j = 0; j < 16; j++) d.push_back(f[j]);
        end
`endif
        ones = 0;
        foreach (d[k]) begin
            if (ones == 5) begin exp_q.push_back(1'b0); ones = 0; end
            exp_q.push_back(d[k]);
            ones = d[k] ? ones + 1 : 0;
        end
        if (fab) begin
            for (int j = 0; j < 8; j++) exp_q.push_back(1'b1);
        end else begin
            if (ones == 5) exp_q.push_back(1'b0);
            for (int k = 0; k < POST; k++)
                for (int j = 0; j < 8; j++) exp_q.push_back(fl[j]);
        end
    endtask

    task automatic drive_buf(input int idx, input int dly);
        if (idx < fn && dly == 0) begin
            dav_tx = 1'b1; tx_byte = fb[idx]; tx_empty = 1'b0;
        end else if (idx < fn || fab) begin
            dav_tx = 1'b0; tx_empty = 1'b0;
        end else begin
            dav_tx = 1'b0; tx_empty = 1'b1;
        end
    endtask

    task automatic run_frame(input string tag, input int exp_acks, input bit exp_done,
                             input bit exp_abort, input int exp_len);
        int   acks, dones, aborts, ptt_cyc, cyc, idx, dly, first_bad, idle_bad, lim;
        logic prev;
        bit   fin;
        acks = 0; dones = 0; aborts = 0; ptt_cyc = 0; cyc = 0; idx = 0; dly = 0;
        fin = 1'b0; first_bad = -1; idle_bad = 0;
        build_exp();
        rec_q.delete();
        prev = tx_bit;
        drive_buf(0, 0);
        start = 1'b1;
        while (!fin && cyc < 3000) begin
            step();
            cyc++;
            if (ptt) begin
                ptt_cyc++;
                rec_q.push_back(tx_bit == prev);
                prev = tx_bit;
            end
            if (ack_tx) begin
                acks++; idx++; dly = $urandom_range(0, 3);
            end else if (dly > 0) begin
                dly--;
            end
            drive_buf(idx, dly);
            if (tx_done) dones++;
            if (tx_abort) aborts++;
            if (tx_done || tx_abort) begin
                fin = 1'b1;
                chk($sformatf("%s ptt_low_at_end", tag), ptt, 1'b0);
            end
            start = !fin && ($urandom_range(0, 3) == 0);
        end
        start = 1'b0;
        chk($sformatf("%s finished_in_budget", tag), fin, 1'b1);
        chk($sformatf("%s ptt_cycles", tag), ptt_cyc, exp_q.size());
        if (exp_len >= 0) chk($sformatf("%s ptt_cycles_const", tag), ptt_cyc, exp_len);
        chk($sformatf("%s acks", tag), acks, exp_acks);
        chk($sformatf("%s done_pulses", tag), dones, exp_done);
        chk($sformatf("%s abort_pulses", tag), aborts, exp_abort);
        lim = (rec_q.size() < exp_q.size()) ? rec_q.size() : exp_q.size();
        for (int k = 0; k < lim; k++)
            if (first_bad < 0 && rec_q[k] != exp_q[k]) first_bad = k;
        chk($sformatf("%s first_bad_bit_index", tag), first_bad, -1);
        // Idle: a byte offered outside PREAMBLE/DATA must be ignored.
        dav_tx = 1'b1; tx_byte = 8'hA5; tx_empty = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (ptt || rfd_tx || ack_tx || tx_done || tx_abort) idle_bad++;
        end
        chk($sformatf("%s idle_quiet", tag), idle_bad, 0);
        dav_tx = 1'b0; tx_empty = 1'b1;
    endtask

    initial begin
        vec_t       vecs [8];
        logic [7:0] got [$];
        logic [7:0] cur;
        logic [8:0] got9;
        int         ones, nb, idle_bad;

        vecs[0] = '{72'h0, 0, 1'b0, 0, 1'b1, 1'b0, 24};
        vecs[1] = '{72'h39_38_37_36_35_34_33_32_31, 9, 1'b0, 9, 1'b1, 1'b0, -1};
        vecs[2] = '{72'hFF, 1, 1'b0, 1, 1'b1, 1'b0, -1};
        vecs[3] = '{72'h5A, 1, 1'b1, 1, 1'b0, 1'b1, 32};
        vecs[4] = '{72'h0, 0, 1'b1, 0, 1'b0, 1'b1, 24};
        vecs[5] = '{72'hFF_FF, 2, 1'b0, 2, 1'b1, 1'b0, -1};
        vecs[6] = '{72'h7E, 1, 1'b0, 1, 1'b1, 1'b0, -1};
        vecs[7] = '{72'h7C_3F, 2, 1'b0, 2, 1'b1, 1'b0, -1};
        for (int i = 0; i < 9; i++) ref3[i] = 8'h31 + 8'(i);
`ifdef HDLC_FCS_EN
        ref3[9] = 8'h6E; ref3[10] = 8'h90;
`else
        ref3[9] = 8'h7E; ref3[10] = 8'h00;
`endif

        reset = 1'b1; start = 1'b0; dav_tx = 1'b0; tx_empty = 1'b1; tx_byte = 8'h00;
        fn = 0; fab = 1'b0;
        step(); step();
        chk("reset ptt", ptt, 1'b0);
        chk("reset rfd_tx", rfd_tx, 1'b0);
        chk("reset ack_tx", ack_tx, 1'b0);
        chk("reset tx_bit", tx_bit, 1'b0);
        chk("reset tx_done", tx_done, 1'b0);
        chk("reset tx_abort", tx_abort, 1'b0);
        reset = 1'b0;
        step();

        for (int v = 0; v < 8; v++) begin
            fn = vecs[v].n; fab = vecs[v].ab;
            for (int i = 0; i < 9; i++) fb[i] = vecs[v].data[8*i +: 8];
            run_frame($sformatf("vec%0d", v), vecs[v].exp_acks, vecs[v].exp_done,
                      vecs[v].exp_abort, vecs[v].exp_len);
            if (v == 1) begin
                got.delete(); ones = 0; nb = 0; cur = '0;
                for (int k = PRE * 8; k < rec_q.size() && got.size() < NB3; k++) begin
                    if (ones == 5 && !rec_q[k]) begin
                        ones = 0;
                    end else begin
                        ones = rec_q[k] ? ones + 1 : 0;
                        cur[nb] = rec_q[k];
                        nb++;
                        if (nb == 8) begin got.push_back(cur); nb = 0; end
                    end
                end
                chk("vec1 destuffed_count", got.size(), NB3);
                for (int k = 0; k < NB3 && k < got.size(); k++)
                    chk($sformatf("vec1 destuffed_byte%0d", k), got[k], ref3[k]);
            end
            if (v == 2) begin
                got9 = '0;
                for (int k = 0; k < 9; k++)
                    if (PRE * 8 + k < rec_q.size()) got9[k] = rec_q[PRE * 8 + k];
                chk("vec2 ff_stuffed_bits", got9, 9'h1DF);
            end
        end

        // Reset in the middle of DATA.
        fn = 4; fab = 1'b0;
        dav_tx = 1'b1; tx_byte = 8'h55; tx_empty = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (21) step();
        chk("midreset ptt_before", ptt, 1'b1);
        reset = 1'b1;
        step();
        chk("midreset ptt", ptt, 1'b0);
        chk("midreset rfd_tx", rfd_tx, 1'b0);
        chk("midreset ack_tx", ack_tx, 1'b0);
        chk("midreset tx_bit", tx_bit, 1'b0);
        step();
        reset = 1'b0; dav_tx = 1'b0; tx_empty = 1'b1;
        idle_bad = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (ptt || rfd_tx || ack_tx || tx_done || tx_abort) idle_bad++;
        end
        chk("midreset idle_after", idle_bad, 0);

        for (int r = 0; r < 25; r++) begin
            fn  = $urandom_range(0, 6);
            fab = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < fn; i++)
                fb[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            run_frame($sformatf("rnd%0d", r), fn, !fab, fab, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
